// File: rtl/multi_debounce.sv
// N-channel push-button conditioner: two-flop synchroniser, symmetric debounce,
// press/release event pulses, and hold detection with optional auto-repeat.
module multi_debounce #(
  parameter int N             = 4,
  parameter int DB_CYCLES     = 16,
  parameter int HOLD_CYCLES   = 1000,
  parameter int REPEAT_CYCLES = 250,
  parameter bit REPEAT_EN     = 1'b1
) (
  input  logic           Clk,
  input  logic           Rst_n,
  input  logic [N-1:0]   BTN,
  output logic [N-1:0]   Debounced,
  output logic [N-1:0]   Press,
  output logic [N-1:0]   Release,
  output logic [N-1:0]   Held,
  output logic [N-1:0]   Repeat,
  output logic [N-1:0]   Strobe,
  output logic [2*N-1:0] dbg_state
);

  localparam int DW   = $clog2(DB_CYCLES);
  localparam int MAXC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] RPT_LAST  = CW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RELEASED = 2'd0,
    S_PRESSED  = 2'd1,
    S_HELD     = 2'd2
  } state_t;

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic          sync0, sync;
    logic          deb_q, deb_n, rise, fall;
    logic [DW-1:0] db_cnt, db_cnt_n;
    state_t        state, state_n;
    logic [CW-1:0] hold_cnt, hold_cnt_n, rpt_cnt, rpt_cnt_n;
    logic          press_q, release_q, held_q, repeat_q, strobe_q;
    logic          press_n, release_n, held_n, repeat_n;

    // Any sample that agrees with the debounced level restarts the count.
    always_comb begin
      db_cnt_n = '0;
      deb_n    = deb_q;
      rise     = 1'b0;
      fall     = 1'b0;
      if (sync != deb_q) begin
        if (db_cnt == DB_LAST) begin
          deb_n = sync;
          rise  = sync;
          fall  = ~sync;
        end else begin
          db_cnt_n = db_cnt + 1'b1;
        end
      end
    end

    // A falling debounced edge wins over everything, cancelling a due repeat.
    always_comb begin
      state_n    = state;
      hold_cnt_n = hold_cnt;
      rpt_cnt_n  = rpt_cnt;
      if (fall) begin
        state_n    = S_RELEASED;
        hold_cnt_n = '0;
        rpt_cnt_n  = '0;
      end else begin
        case (state)
          S_RELEASED: begin
            if (rise) begin
              state_n    = S_PRESSED;
              hold_cnt_n = '0;
            end
          end
          S_PRESSED: begin
            if (hold_cnt == HOLD_LAST) begin
              state_n    = S_HELD;
              hold_cnt_n = '0;
              rpt_cnt_n  = '0;
            end else begin
              hold_cnt_n = hold_cnt + 1'b1;
            end
          end
          S_HELD: begin
            if (rpt_cnt == RPT_LAST) rpt_cnt_n = '0;
            else                     rpt_cnt_n = rpt_cnt + 1'b1;
          end
          default: state_n = S_RELEASED;
        endcase
      end
    end

    always_comb begin
      press_n   = rise;
      release_n = fall;
      held_n    = (state_n == S_HELD);
      repeat_n  = 1'b0;
      if (REPEAT_EN && !fall) begin
        if (state == S_PRESSED && hold_cnt == HOLD_LAST) repeat_n = 1'b1;
        if (state == S_HELD && rpt_cnt == RPT_LAST)      repeat_n = 1'b1;
      end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
        sync0     <= 1'b0;
        sync      <= 1'b0;
        deb_q     <= 1'b0;
        db_cnt    <= '0;
        state     <= S_RELEASED;
        hold_cnt  <= '0;
        rpt_cnt   <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        held_q    <= 1'b0;
        repeat_q  <= 1'b0;
        strobe_q  <= 1'b0;
      end else begin
        sync0     <= BTN[i];
        sync      <= sync0;
        deb_q     <= deb_n;
        db_cnt    <= db_cnt_n;
        state     <= state_n;
        hold_cnt  <= hold_cnt_n;
        rpt_cnt   <= rpt_cnt_n;
        press_q   <= press_n;
        release_q <= release_n;
        held_q    <= held_n;
        repeat_q  <= repeat_n;
        strobe_q  <= press_n | repeat_n;
      end
    end

    assign Debounced[i]       = deb_q;
    assign Press[i]           = press_q;
    assign Release[i]         = release_q;
    assign Held[i]            = held_q;
    assign Repeat[i]          = repeat_q;
    assign Strobe[i]          = strobe_q;
    assign dbg_state[2*i +: 2] = state;
  end

endmodule

// File: tb/tb_multi_debounce.sv
// Bench for multi_debounce: two instances (repeat on/off) share stimulus and are
// checked every cycle against an age-based model plus directed literal checks.
module tb_multi_debounce;
  localparam int N    = 2;
  localparam int DB   = 4;
  localparam int HOLD = 20;
  localparam int RPT  = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0] btn;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [N-1:0]   deb, press, rel, held, rep, strobe;
  logic [N-1:0]   deb2, press2, rel2, held2, rep2, strobe2;
  logic [2*N-1:0] st, st2;

  multi_debounce #(.N(N), .DB_CYCLES(DB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(RPT),
                   .REPEAT_EN(1'b1)) dut (
    .Clk(clk), .Rst_n(rst_n), .BTN(btn), .Debounced(deb), .Press(press),
    .Release(rel), .Held(held), .Repeat(rep), .Strobe(strobe), .dbg_state(st));

  multi_debounce #(.N(N), .DB_CYCLES(DB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(RPT),
                   .REPEAT_EN(1'b0)) dut_nr (
    .Clk(clk), .Rst_n(rst_n), .BTN(btn), .Debounced(deb2), .Press(press2),
    .Release(rel2), .Held(held2), .Repeat(rep2), .Strobe(strobe2), .dbg_state(st2));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: count disagreeing samples, then track age (edges since press).
  bit m_s0[N], m_s1[N], m_deb[N], m_press[N], m_rel[N];
  int m_run[N], m_age[N];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N; c++) begin
        m_s0[c] = 0; m_s1[c] = 0; m_deb[c] = 0; m_press[c] = 0; m_rel[c] = 0;
        m_run[c] = 0; m_age[c] = 0;
      end
    end else begin
      for (int c = 0; c < N; c++) begin
        m_press[c] = 0;
        m_rel[c]   = 0;
        if (m_s1[c] != m_deb[c]) m_run[c]++;
        else                     m_run[c] = 0;
        if (m_run[c] == DB) begin
          m_deb[c]   = m_s1[c];
          m_run[c]   = 0;
          m_press[c] = m_deb[c];
          m_rel[c]   = !m_deb[c];
        end
        m_s1[c] = m_s0[c];
        m_s0[c] = btn[c];
        if (m_press[c])    m_age[c] = 0;
        else if (m_deb[c]) m_age[c]++;
      end
    end
  end

  function automatic logic [N-1:0] e_deb();
    for (int c = 0; c < N; c++) e_deb[c] = m_deb[c];
  endfunction
  function automatic logic [N-1:0] e_press();
    for (int c = 0; c < N; c++) e_press[c] = m_press[c];
  endfunction
  function automatic logic [N-1:0] e_rel();
    for (int c = 0; c < N; c++) e_rel[c] = m_rel[c];
  endfunction
  function automatic logic [N-1:0] e_held();
    for (int c = 0; c < N; c++) e_held[c] = m_deb[c] && (m_age[c] >= HOLD);
  endfunction
  function automatic logic [N-1:0] e_rep();
    for (int c = 0; c < N; c++)
      e_rep[c] = m_deb[c] && (m_age[c] >= HOLD) && ((m_age[c] - HOLD) % RPT == 0);
  endfunction

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    #1;
    chk("deb",      deb,     e_deb());
    chk("press",    press,   e_press());
    chk("release",  rel,     e_rel());
    chk("held",     held,    e_held());
    chk("repeat",   rep,     e_rep());
    chk("strobe",   strobe,  e_press() | e_rep());
    chk("nr_deb",   deb2,    e_deb());
    chk("nr_press", press2,  e_press());
    chk("nr_rel",   rel2,    e_rel());
    chk("nr_held",  held2,   e_held());
    chk("nr_rep",   rep2,    '0);
    chk("nr_strb",  strobe2, e_press());
  end

  task automatic wait_to(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  int base, p, t, t2, ta, tb, base2;
  logic [4:0] pat;

  initial begin
    rst_n = 1'b0;
    btn   = 2'b11;
    repeat (3) @(negedge clk);
    chk("rst_deb",    deb,    2'b00);
    chk("rst_press",  press,  2'b00);
    chk("rst_strobe", strobe, 2'b00);

    // Reset release with buttons already high: press after edge 5.
    rst_n = 1'b1;
    base  = cyc;
    wait_to(base + 5);
    chk("lat_press_early", press, 2'b00);
    wait_to(base + 6);
    chk("lat_press",       press, 2'b11);
    chk("lat_deb",         deb,   2'b11);
    chk("pin_model_press", e_press(), 2'b11);
    p = base + 6;
    wait_to(p + 1);
    chk("press_width",     press, 2'b00);

    // Hold and repeat.
    wait_to(p + 19);
    chk("held_early",   held, 2'b00);
    wait_to(p + 20);
    chk("held_on",      held,    2'b11);
    chk("rep_first",    rep,     2'b11);
    chk("strobe_rep",   strobe,  2'b11);
    chk("nr_held_on",   held2,   2'b11);
    chk("nr_strobe",    strobe2, 2'b00);
    chk("pin_model_held", e_held(), 2'b11);
    wait_to(p + 27);
    chk("rep_gap",      rep,  2'b00);
    wait_to(p + 28);
    chk("rep_second",   rep,  2'b11);

    // ch0 falls exactly on its p+36 repeat edge; ch1 repeats there.
    wait_to(p + 30);
    btn = 2'b10;
    wait_to(p + 35);
    chk("bnd_pre_held", held, 2'b11);
    wait_to(p + 36);
    chk("bnd_release",  rel,    2'b01);
    chk("bnd_repeat",   rep,    2'b10);
    chk("bnd_held",     held,   2'b10);
    chk("bnd_strobe",   strobe, 2'b10);
    chk("pin_model_bnd", e_rep(), 2'b10);
    wait_to(p + 60);
    btn = 2'b00;
    wait_to(p + 66);
    chk("ch1_release", rel,  2'b10);
    chk("ch1_held",    held, 2'b00);

    // Bounce on press, then mirrored bounce on release.
    wait_to(p + 75);
    pat = 5'b01101;  // applied LSB first: 1,0,1,1,0
    for (int k = 0; k < 5; k++) begin
      btn[0] = pat[k];
      @(negedge clk);
    end
    btn[0] = 1'b1;
    t = cyc + 1;
    wait_to(t + 4);
    chk("bounce_no_press", press, 2'b00);
    wait_to(t + 5);
    chk("bounce_press",    press, 2'b01);
    wait_to(t + 8);
    pat = 5'b10010;  // 0,1,0,0,1
    for (int k = 0; k < 5; k++) begin
      btn[0] = pat[k];
      @(negedge clk);
    end
    btn[0] = 1'b0;
    t2 = cyc + 1;
    wait_to(t2 + 4);
    chk("bounce_no_rel", rel, 2'b00);
    wait_to(t2 + 5);
    chk("bounce_rel",    rel, 2'b01);
    wait_to(t2 + 6);
    chk("bounce_rel_w",  rel, 2'b00);

    // Independence: staggered by two cycles, then simultaneous.
    wait_to(t2 + 12);
    btn[0] = 1'b1;
    ta = cyc + 1;
    @(negedge clk);
    @(negedge clk);
    btn[1] = 1'b1;
    wait_to(ta + 5);
    chk("stag_ch0", press, 2'b01);
    wait_to(ta + 7);
    chk("stag_ch1", press, 2'b10);
    wait_to(ta + 10);
    btn = 2'b00;
    wait_to(ta + 16);
    chk("sim_release", rel, 2'b11);
    wait_to(ta + 20);
    btn = 2'b11;
    tb = cyc + 1;
    wait_to(tb + 5);
    chk("sim_press", press, 2'b11);

    // Reset mid-press: clears at once, then a fresh full-latency press.
    wait_to(tb + 10);
    rst_n = 1'b0;
    #1;
    chk("midrst_deb",  deb,  2'b00);
    chk("midrst_held", held, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    base2 = cyc;
    wait_to(base2 + 5);
    chk("rerst_early", press, 2'b00);
    wait_to(base2 + 6);
    chk("rerst_press", press, 2'b11);
    wait_to(base2 + 10);
    btn = 2'b00;
    wait_to(base2 + 25);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_debounce.md
# multi_debounce

Parametrised N-channel push-button conditioner: two-flop synchroniser, symmetric debounce on press and release, one-cycle press/release event pulses, and optional hold-to-repeat. It sits between raw board buttons and any logic that counts or reacts to presses. It supersedes single-button, press-only debouncers that release on the first low sample.

## Interface
- N, 4, number of independent button channels (≥1)
- DB_CYCLES, 16, consecutive disagreeing synchronised samples needed to flip the debounced state (≥2)
- HOLD_CYCLES, 1000, cycles of debounced-high before Held asserts (≥1)
- REPEAT_CYCLES, 250, period of Repeat pulses while held (≥1)
- REPEAT_EN, 1, 1 = generate Repeat pulses; 0 = Repeat tied low, Held still works
- Clk  input  1  system clock, all state on rising edge
- Rst_n  input  1  reset, asynchronous, active-low
- BTN  input  N  raw asynchronous buttons, active-high
- Debounced  output  N  debounced level per channel
- Press  output  N  one-cycle pulse on debounced rising edge
- Release  output  N  one-cycle pulse on debounced falling edge
- Held  output  N  level, high while the channel has been debounced-high ≥ HOLD_CYCLES
- Repeat  output  N  one-cycle pulse at hold start and every REPEAT_CYCLES thereafter
- Strobe  output  N  Press | Repeat, registered, for direct use as a counter enable

## Operation
- Rst_n low: all synchroniser flops, counters, state and every output go to 0 immediately. Deassertion is synchronised to Clk at top level.
- Per channel, fully independent. No cross-channel interaction.
- Synchroniser: Sync0 <= BTN[i]; Sync <= Sync0.
- Debounce counter DbCnt, width $clog2(DB_CYCLES):
  - Sync == Debounced: DbCnt <= 0.
  - Sync != Debounced and DbCnt < DB_CYCLES-1: DbCnt <= DbCnt+1.
  - Sync != Debounced and DbCnt == DB_CYCLES-1: Debounced <= Sync, DbCnt <= 0.
  - Any agreeing sample restarts the count. Glitches shorter than DB_CYCLES samples are ignored in both directions.
- Hold FSM, states RELEASED, PRESSED, HELD:
  - RELEASED -> PRESSED on the edge Debounced rises. HoldCnt <= 0. Press=1 for that cycle.
  - PRESSED: HoldCnt increments each cycle. When HoldCnt == HOLD_CYCLES-1, go to HELD, Held <= 1, Repeat <= REPEAT_EN, RptCnt <= 0.
  - HELD: RptCnt increments. When RptCnt == REPEAT_CYCLES-1, Repeat <= REPEAT_EN and RptCnt <= 0.
  - PRESSED or HELD -> RELEASED on the edge Debounced falls. Release=1, Held <= 0, counters cleared. A Repeat due on that same edge is suppressed.
- HoldCnt and RptCnt width: $clog2(max(HOLD_CYCLES, REPEAT_CYCLES)+1). They never wrap; each is cleared on its compare match.
- Strobe = registered OR of the Press and Repeat conditions. It is asserted in the same cycle as those outputs.

## Timing
- All outputs are registered. Press, Release, Repeat and Strobe are exactly one cycle wide.
- Press latency: BTN goes high and stays high before edge t. Sync0=1 after edge t, Sync=1 after edge t+1. Debounced=1 and Press=1 after edge t+DB_CYCLES+1. Press clears after edge t+DB_CYCLES+2.
- Release latency is identical and symmetric.
- Held and the first Repeat assert HOLD_CYCLES edges after Press asserts. Subsequent Repeats follow every REPEAT_CYCLES edges.
- Press and Release on one channel are never simultaneous. Different channels may pulse in the same cycle.
- Reset mid-press: outputs clear at once. If BTN is still high after release of reset, it is a new press with full latency and Press is generated.

## Test plan
Bench parameters: N=2, DB_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8, REPEAT_EN=1.
- Reset: Rst_n=0 with BTN=2'b11 -> all outputs 0. Release reset with BTN high at edge 0 -> Debounced[0]=1 and Press[0]=1 after edge 5 only, one cycle wide.
- Bounce: BTN[0] toggles 1,0,1,1,0 (one sample each), then holds 1 -> no Press during bounce. Press occurs 5 edges after the final stable-high sample. Mirror test on release gives a single Release pulse.
- Hold/repeat: BTN[0] held 60 cycles -> Held and Repeat at Press+20. Repeat at +28, +36, +44, … Strobe on Press and every Repeat. Release clears Held with the Release pulse.
- Release on repeat boundary: drop BTN so Debounced falls on the edge a Repeat would fire -> Release=1, Repeat=0, Held=0.
- Independence: press ch0 and ch1 staggered by 2 cycles, then simultaneously -> correct per-channel latencies and coincident pulses with no interference.
- REPEAT_EN=0 rebuild: hold 60 cycles -> Held asserts at Press+20, Repeat never asserts, Strobe only on Press.
